// File: rtl/chrono_command_fsm_if.sv
// Button inputs and datapath control outputs of the stopwatch command sequencer.
// No handshake: buttons are raw async levels, controls are levels or one-cycle pulses that the datapath must sample every cycle.
interface chrono_command_fsm_if;
    logic       btn_ss;
    logic       btn_lr;
    logic       count_en;
    logic       counter_reset;
    logic       lap_hold;
    logic       lap_capture;
    logic [2:0] state;

    modport master (
        output btn_ss, btn_lr,
        input  count_en, counter_reset, lap_hold, lap_capture, state
    );

    modport slave (
        input  btn_ss, btn_lr,
        output count_en, counter_reset, lap_hold, lap_capture, state
    );
endinterface

// File: rtl/chrono_command_fsm.sv
// Stopwatch command sequencer: synchronises and debounces the SS/LR buttons and
// runs the run/stop/lap/clear state machine that drives the counter datapath.
module chrono_command_fsm #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int LONG_TICKS     = 1000
) (
    input  logic                 qzt_clk,
    input  logic                 reset_n,
    chrono_command_fsm_if.slave  cmd
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STOP     = 3'd2,
        LAP_RUN  = 3'd3,
        LAP_STOP = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    logic [15:0]      tick_cnt;
    logic             tick;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [1:0][7:0]  deb_cnt;
    logic [15:0]      hold_cnt;
    logic             ss_ev;
    logic             lr_ev;
    logic             lr_long;
    state_t           state_q;
    state_t           state_nxt;
    logic             count_en_q;
    logic             counter_reset_q;
    logic             lap_hold_q;
    logic             lap_capture_q;

    assign tick = (tick_cnt == 16'(TICK_DIV - 1));

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Bit 0 is SS, bit 1 is LR throughout the input path.
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_d   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= {cmd.btn_lr, cmd.btn_ss};
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (deb_cnt[i] == 8'(DEBOUNCE_TICKS - 1)) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Saturating at LONG_TICKS makes the long-press event fire once per hold.
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (!deb[1]) begin
            hold_cnt <= '0;
        end else if (tick && (hold_cnt != 16'(LONG_TICKS))) begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign ss_ev   = deb[0] & ~deb_d[0];
    assign lr_ev   = deb[1] & ~deb_d[1];
    assign lr_long = deb[1] & tick & (hold_cnt == 16'(LONG_TICKS - 1));

    // Priority lr_long > ss_ev > lr_ev; losing events are dropped.
    always_comb begin
        state_nxt = IDLE;
        case (state_q)
            IDLE:     state_nxt = lr_long ? CLEAR : (ss_ev ? RUN : IDLE);
            RUN:      state_nxt = lr_long ? CLEAR : (ss_ev ? STOP : (lr_ev ? LAP_RUN : RUN));
            STOP:     state_nxt = lr_long ? CLEAR : (ss_ev ? RUN : (lr_ev ? CLEAR : STOP));
            LAP_RUN:  state_nxt = lr_long ? CLEAR : (ss_ev ? LAP_STOP : (lr_ev ? RUN : LAP_RUN));
            LAP_STOP: state_nxt = lr_long ? CLEAR : (ss_ev ? LAP_RUN : (lr_ev ? STOP : LAP_STOP));
            CLEAR:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            count_en_q      <= 1'b0;
            counter_reset_q <= 1'b0;
            lap_hold_q      <= 1'b0;
            lap_capture_q   <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            count_en_q      <= (state_nxt == RUN) || (state_nxt == LAP_RUN);
            counter_reset_q <= (state_nxt == CLEAR);
            lap_hold_q      <= (state_nxt == LAP_RUN) || (state_nxt == LAP_STOP);
            lap_capture_q   <= ((state_nxt == LAP_RUN) || (state_nxt == LAP_STOP)) &&
                               ((state_q == RUN) || (state_q == STOP));
        end
    end

    assign cmd.state         = state_q;
    assign cmd.count_en      = count_en_q;
    assign cmd.counter_reset = counter_reset_q;
    assign cmd.lap_hold      = lap_hold_q;
    assign cmd.lap_capture   = lap_capture_q;

endmodule

// File: tb/tb_chrono_command_fsm.sv
// Bench for chrono_command_fsm: hand-written press table, corner sequences and
// random presses checked against a press-level model of the stopwatch.
module tb_chrono_command_fsm;
    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int LONG     = 20;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STOP = 3'd2,
                           S_LAP_RUN = 3'd3, S_LAP_STOP = 3'd4, S_CLEAR = 3'd5;

    logic qzt_clk = 1'b0;
    logic reset_n = 1'b0;

    chrono_command_fsm_if cmd_if ();

    chrono_command_fsm #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LONG)
    ) dut (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .cmd     (cmd_if)
    );

    always #5 qzt_clk = ~qzt_clk;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] m_state;
    int         exp_cap;
    int         exp_clr;
    int         cap_cycles;
    int         clr_cycles;
    logic [2:0] ss_tbl[6];
    logic [2:0] lr_tbl[6];
    bit         mon_en = 1'b0;
    logic [2:0] prev_state;

    typedef struct {
        bit         ss;
        bit         lr;
        bit         lng;
        int         hold;
        logic [2:0] st;
        bit         en;
        bit         hd;
        int         cap;
        int         clr;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    // Scoreboard: every observed state change must match the next expected state.
    always @(negedge qzt_clk) begin
        if (mon_en) begin
            if (cmd_if.lap_capture) cap_cycles++;
            if (cmd_if.counter_reset) clr_cycles++;
            if (cmd_if.state !== prev_state) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL state_seq: got %0d expected no change from %0d",
                             cmd_if.state, prev_state);
                end else begin
                    check("state_seq", int'(cmd_if.state), int'(exp_q.pop_front()));
                end
                prev_state = cmd_if.state;
            end
        end
    end

    task automatic model_apply(input logic [2:0] nxt);
        if (nxt != m_state) begin
            exp_q.push_back(nxt);
            if (((nxt == S_LAP_RUN) || (nxt == S_LAP_STOP)) &&
                ((m_state == S_RUN) || (m_state == S_STOP)))
                exp_cap++;
            if (nxt == S_CLEAR) begin
                exp_clr++;
                exp_q.push_back(S_IDLE);
                m_state = S_IDLE;
            end else begin
                m_state = nxt;
            end
        end
    endtask

    task automatic start_op();
        cap_cycles = 0;
        clr_cycles = 0;
        exp_cap    = 0;
        exp_clr    = 0;
    endtask

    task automatic verify_settled(input string tag);
        check({tag, "_state"}, int'(cmd_if.state), int'(m_state));
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_count_en"}, int'(cmd_if.count_en),
              int'((m_state == S_RUN) || (m_state == S_LAP_RUN)));
        check({tag, "_lap_hold"}, int'(cmd_if.lap_hold),
              int'((m_state == S_LAP_RUN) || (m_state == S_LAP_STOP)));
        check({tag, "_capture_cycles"}, cap_cycles, exp_cap);
        check({tag, "_clear_cycles"}, clr_cycles, exp_clr);
        exp_q.delete();
    endtask

    task automatic run_op(input bit ss, input bit lr, input int hold, input bit lng);
        start_op();
        if (ss) model_apply(ss_tbl[m_state]);
        else if (lr) model_apply(lr_tbl[m_state]);
        if (lng) model_apply(S_CLEAR);
        cmd_if.btn_ss = ss;
        cmd_if.btn_lr = lr;
        wait_clk(hold);
        cmd_if.btn_ss = 1'b0;
        cmd_if.btn_lr = 1'b0;
        wait_clk(40);
    endtask

    task automatic glitch_op(input bit on_lr, input int len);
        start_op();
        if (on_lr) cmd_if.btn_lr = 1'b1;
        else cmd_if.btn_ss = 1'b1;
        wait_clk(len);
        cmd_if.btn_ss = 1'b0;
        cmd_if.btn_lr = 1'b0;
        wait_clk(40);
        verify_settled("glitch");
    endtask

    initial begin
        ss_tbl = '{S_RUN, S_STOP, S_RUN, S_LAP_STOP, S_LAP_RUN, S_IDLE};
        lr_tbl = '{S_IDLE, S_LAP_RUN, S_CLEAR, S_RUN, S_STOP, S_IDLE};

        //          ss lr lng hold state       en hd cap clr
        vecs[0]  = '{1, 0, 0, 40,  S_RUN,      1, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 40,  S_STOP,     0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 40,  S_RUN,      1, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 40,  S_LAP_RUN,  1, 1, 1, 0};
        vecs[4]  = '{1, 0, 0, 40,  S_LAP_STOP, 0, 1, 0, 0};
        vecs[5]  = '{0, 1, 0, 40,  S_STOP,     0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 40,  S_IDLE,     0, 0, 0, 1};
        vecs[7]  = '{1, 0, 0, 40,  S_RUN,      1, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 120, S_IDLE,     0, 0, 1, 1};
        vecs[9]  = '{1, 0, 0, 40,  S_RUN,      1, 0, 0, 0};
        vecs[10] = '{1, 1, 0, 40,  S_STOP,     0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 40,  S_IDLE,     0, 0, 0, 1};

        cmd_if.btn_ss = 1'b0;
        cmd_if.btn_lr = 1'b0;
        reset_n       = 1'b0;
        wait_clk(3);
        check("reset_state", int'(cmd_if.state), 0);
        check("reset_count_en", int'(cmd_if.count_en), 0);
        check("reset_lap_hold", int'(cmd_if.lap_hold), 0);
        check("reset_counter_reset", int'(cmd_if.counter_reset), 0);
        check("reset_lap_capture", int'(cmd_if.lap_capture), 0);
        #1 reset_n = 1'b1;
        wait_clk(2);
        m_state    = S_IDLE;
        prev_state = cmd_if.state;
        mon_en     = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].ss, vecs[i].lr, vecs[i].hold, vecs[i].lng);
            check("vec_state", int'(cmd_if.state), int'(vecs[i].st));
            check("vec_count_en", int'(cmd_if.count_en), int'(vecs[i].en));
            check("vec_lap_hold", int'(cmd_if.lap_hold), int'(vecs[i].hd));
            check("vec_capture_cycles", cap_cycles, vecs[i].cap);
            check("vec_clear_cycles", clr_cycles, vecs[i].clr);
            verify_settled("vec_model");
        end

        // Contact bounce in IDLE: 3-clk pulses every 6 clk must never register.
        start_op();
        for (int i = 0; i < 10; i++) begin
            cmd_if.btn_ss = 1'b1;
            wait_clk(3);
            cmd_if.btn_ss = 1'b0;
            wait_clk(3);
        end
        wait_clk(40);
        verify_settled("bounce");

        // Reset mid-debounce from RUN; the still-held button is a fresh press.
        run_op(1'b1, 1'b0, 40, 1'b0);
        verify_settled("pre_reset");
        start_op();
        model_apply(S_IDLE);
        cmd_if.btn_ss = 1'b1;
        wait_clk(8);
        #1 reset_n = 1'b0;
        wait_clk(3);
        check("midreset_state", int'(cmd_if.state), 0);
        check("midreset_count_en", int'(cmd_if.count_en), 0);
        model_apply(S_RUN);
        #1 reset_n = 1'b1;
        wait_clk(40);
        cmd_if.btn_ss = 1'b0;
        wait_clk(40);
        verify_settled("post_reset");

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 3) run_op(1'b1, 1'b0, $urandom_range(20, 60), 1'b0);
            else if (kind <= 6) run_op(1'b0, 1'b1, $urandom_range(20, 60), 1'b0);
            else if (kind == 7) run_op(1'b0, 1'b1, $urandom_range(120, 150), 1'b1);
            else if (kind == 9) run_op(1'b1, 1'b1, $urandom_range(20, 60), 1'b0);
            if (kind == 8) glitch_op(1'($urandom_range(0, 1)), $urandom_range(1, 7));
            else verify_settled("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chrono_command_fsm.md
Name: chrono_command_fsm

Overview:
- Command sequencer for the stopwatch datapath. Replaces the monostable and toggle flip-flop chain used to interpret the two push buttons.
- Synchronises and debounces the start/stop (SS) and lap/reset (LR) buttons, then runs one state machine.
- Drives the datapath controls: counter enable, counter clear, lap latch hold and latch capture.
- Sits between the raw buttons and the BCD counter chain, lap latch and LCD driver.

Parameters:
- TICK_DIV, 50000: qzt_clk cycles per internal 1 ms tick (must be ≥2, ≤65535).
- DEBOUNCE_TICKS, 5: ticks an input must differ from its debounced level before the debounced level flips (1..255).
- LONG_TICKS, 1000: ticks LR must be held (debounced) to produce a long-press master clear (DEBOUNCE_TICKS < LONG_TICKS ≤ 65535).

Ports:
- qzt_clk  input  1  50 MHz system clock.
- reset_n  input  1  Asynchronous active-low reset.
- btn_ss  input  1  Raw start/stop button, asynchronous, active-high.
- btn_lr  input  1  Raw lap/reset button, asynchronous, active-high.
- count_en  output  1  Gates the 100 Hz enable into the counter chain.
- counter_reset  output  1  One-cycle clear pulse to all counters.
- lap_hold  output  1  Level: lap latch frozen (display shows the latched value).
- lap_capture  output  1  One-cycle pulse on entry to any LAP state, so the latch loads the current count.
- state  output  3  Current FSM state, for LEDs and debug.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; all outputs 0; synchronisers, debounced levels, tick, debounce and hold counters all 0.
- Tick: a 16-bit prescaler counts 0..TICK_DIV-1 and asserts an internal one-cycle tick at the wrap.
- Input path: 2-FF synchroniser per button, then debounce.
  - The debounce counter increments on each tick while the synced level ≠ debounced level, and clears whenever they are equal.
  - On reaching DEBOUNCE_TICKS, the debounced level toggles and the counter clears.
- Events (one qzt_clk cycle each):
  - ss_ev: debounced SS rising edge.
  - lr_ev: debounced LR rising edge.
  - lr_long: hold counter reaches LONG_TICKS.
    - The hold counter increments per tick while debounced LR=1 and saturates at LONG_TICKS.
    - It clears when debounced LR=0.
    - lr_long fires exactly once per hold.
- Releases generate no events.
- States (encoding): IDLE=0, RUN=1, STOP=2, LAP_RUN=3, LAP_STOP=4, CLEAR=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Transitions (evaluated on the edge after the event cycle):
  - IDLE: ss_ev→RUN; lr_ev ignored.
  - RUN: ss_ev→STOP; lr_ev→LAP_RUN.
  - STOP: ss_ev→RUN; lr_ev→CLEAR.
  - LAP_RUN: ss_ev→LAP_STOP; lr_ev→RUN (display released, live).
  - LAP_STOP: ss_ev→LAP_RUN; lr_ev→STOP.
  - CLEAR: unconditionally →IDLE after one cycle.
  - Any state except CLEAR: lr_long→CLEAR.
- Priority within one cycle: lr_long > ss_ev > lr_ev. A lower-priority event in the same cycle is dropped, not queued.
- Outputs (Moore decode of the state register, registered where marked):
  - count_en=1 in RUN and LAP_RUN.
  - lap_hold=1 in LAP_RUN and LAP_STOP.
  - counter_reset=1 only in CLEAR.
  - lap_capture registered: 1 for exactly the first cycle after entering LAP_RUN or LAP_STOP from RUN or STOP. No pulse on LAP_RUN↔LAP_STOP.
- Latency:
  - A raw edge held stable produces its event 2 clk + DEBOUNCE_TICKS ticks (±1 tick of phase) + 1 clk later.
  - The state changes 1 clk after the event.
- Long press: the short-press action (lr_ev) fires first; lr_long then forces CLEAR. So a long press from RUN gives LAP_RUN, then CLEAR, then IDLE.
- Glitches shorter than DEBOUNCE_TICKS ticks produce no event and no debounced-level change.
- reset_n asserted mid-debounce or mid-hold discards all partial counts. After release, a still-held button is seen as a new press after full debounce.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=20):
- Reset: pulse reset_n low with buttons idle → state=0; count_en, lap_hold, counter_reset and lap_capture all 0.
- Start/stop: SS press held 40 clk then released; repeat → state 0→1 (count_en=1) then 1→2 (count_en=0). Exactly one ss_ev per press.
- Bounce: 3-clk SS glitches every 6 clk for 60 clk in IDLE → state stays 0; no event.
- Lap: RUN, then LR press → state=3, lap_hold=1, lap_capture high for exactly 1 cycle, count_en=1. SS press → state=4, no lap_capture. LR press → state=2, lap_hold=0.
- Reset: in STOP, LR press → state=5 with counter_reset=1 for exactly one cycle, then state=0.
- Long press and priority:
  - From RUN, hold LR for 100 clk → 3, then 5, then 0, with a single counter_reset pulse.
  - SS and LR debounced edges forced in the same cycle from RUN → state=2.
